// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch (IF)
// and data access (MEM). One transaction is in flight at a time; MEM has
// priority, and a starvation counter forces an IF grant after STARVE_MAX
// consecutive MEM grants made while IF was waiting.
module mem_port_arbiter #(
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        stallreq,
  output logic        busy
);

  localparam logic [2:0] LAT_INIT   = 3'(RAM_LAT);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        owner_mem_q, owner_mem_d;   // 1: MEM owns the transaction
  logic        cmd_we_q, cmd_we_d;
  logic [2:0]  lat_q, lat_d;
  logic [2:0]  starve_q, starve_d;
  logic        ram_ce_q, ram_ce_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [3:0]  ram_sel_q, ram_sel_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        busy_q, busy_d;

  logic        force_if_s;
  logic        grant_mem_s;
  logic        grant_if_s;

  // Arbitration decision on the current-cycle requests (used at IDLE and DONE)
  always_comb begin
    force_if_s  = if_req & (starve_q == STARVE_LIM);
    grant_mem_s = mem_req & ~force_if_s;
    grant_if_s  = ~grant_mem_s & if_req;
  end

  // Next-state and registered-output logic of the transaction sequencer
  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    cmd_we_d    = cmd_we_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    ram_ce_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (grant_mem_s) begin
          owner_mem_d = 1'b1;
          cmd_we_d    = mem_we;
          ram_ce_d    = 1'b1;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_sel_d   = mem_sel;
          ram_wdata_d = mem_wdata;
          // A MEM grant only counts against IF when IF is actually waiting
          if (if_req) begin
            starve_d = starve_q + 3'd1;
          end else begin
            starve_d = 3'd0;
          end
          state_d = ST_ISSUE;
        end else if (grant_if_s) begin
          owner_mem_d = 1'b0;
          cmd_we_d    = 1'b0;
          ram_ce_d    = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = if_addr;
          ram_sel_d   = 4'b1111;
          ram_wdata_d = 32'h0000_0000;
          starve_d    = 3'd0;
          state_d     = ST_ISSUE;
        end else begin
          starve_d = 3'd0;
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == 3'd1) begin
          if (owner_mem_q) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = cmd_we_q ? 32'h0000_0000 : ram_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = ram_rdata;
          end
          state_d = ST_DONE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_mem_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      lat_q       <= 3'd0;
      starve_q    <= 3'd0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'h0000_0000;
      ram_sel_q   <= 4'b0000;
      ram_wdata_q <= 32'h0000_0000;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      mem_rdata_q <= 32'h0000_0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      cmd_we_q    <= cmd_we_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_sel   = ram_sel_q;
  assign ram_wdata = ram_wdata_q;
  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = busy_q;

  // The pipeline stalls while any request is outstanding and not yet acked
  assign stallreq  = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port instruction/data RAM of the mymips SOPC between the fetch stage (IF) and the memory-access stage (MEM). Each transaction is registered and sequenced through a small state machine, and the block returns one-cycle acks with read data. MEM has priority; a starvation counter guarantees IF forward progress. It sits between the CPU core's bus ports and the RAM inside `mymips_sopc`.

## Interface
- `RAM_LAT`, 1: cycles from the `ram_ce` cycle to valid `ram_rdata` (legal 1..4).
- `STARVE_MAX`, 2: consecutive MEM grants allowed while IF is waiting before IF is forced (legal 1..7).
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-low.
- `if_req` input 1: IF read request; hold until `if_ack`.
- `if_addr` input 32: IF byte address.
- `if_ack` output 1: one-cycle completion pulse.
- `if_rdata` output 32: instruction; valid only while `if_ack`=1.
- `mem_req` input 1: MEM request; hold until `mem_ack`.
- `mem_we` input 1: 1=write, 0=read.
- `mem_addr` input 32: MEM byte address.
- `mem_sel` input 4: byte enables.
- `mem_wdata` input 32: write data.
- `mem_ack` output 1: one-cycle completion pulse.
- `mem_rdata` output 32: load data while `mem_ack`=1; 0 on write acks.
- `ram_ce` output 1: RAM access strobe, exactly one cycle per transaction.
- `ram_we` output 1: RAM write enable, only with `ram_ce`.
- `ram_addr` output 32, `ram_sel` output 4, `ram_wdata` output 32: registered RAM command.
- `ram_rdata` input 32: RAM read data.
- `stallreq` output 1: combinational `(if_req & ~if_ack) | (mem_req & ~mem_ack)`, to the pipeline ctrl.
- `busy` output 1: high when state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
  - **IDLE:** arbitrate on the current-cycle `if_req` and `mem_req`.
    - Grant MEM if `mem_req` is high and the condition `if_req & starve_cnt==STARVE_MAX` is false.
    - Else grant IF if `if_req` is high.
    - Else stay in IDLE.
    - On a grant, capture owner, address, sel, wdata and we (IF forces we=0, sel=4'b1111), then go to ISSUE.
  - **ISSUE:** `ram_ce`=1 with the captured command for one cycle. Load the latency counter with `RAM_LAT`, then go to WAIT.
  - **WAIT:** decrement the counter each cycle. In the cycle where the counter reaches 1, latch `ram_rdata` into the owner's rdata register, then go to DONE.
  - **DONE:** pulse the owner's ack for one cycle with the registered data, then go to IDLE.
- DONE also arbitrates exactly as IDLE does. A request visible during the ack cycle is a new request, which makes back-to-back issue possible: the next ISSUE is the cycle after DONE.
- Starvation counter `starve_cnt`, 3 bits:
  - Increments on each MEM grant made while `if_req`=1, saturating at `STARVE_MAX`.
  - Clears on any IF grant.
  - Clears at any arbitration point where `if_req`=0.
- Requests and payloads are sampled only at arbitration points. Changes while the block is busy are ignored.
- A request dropped before its ack still completes. RAM is accessed and the ack pulses anyway.
- Only the owner's ack/rdata changes. The non-owner's rdata holds its previous value.

## Timing
- All of these are 0 after reset: `ram_ce`, `ram_we`, `ram_addr`, `ram_sel`, `ram_wdata`, `if_ack`, `mem_ack`, `if_rdata`, `mem_rdata`, `busy`, `starve_cnt`. State is IDLE.
- For a request seen at arbitration cycle c0:
  - `ram_ce` is high in c1.
  - `ram_rdata` is sampled in c(1+RAM_LAT).
  - The ack is in c(2+RAM_LAT).
  - The latency is the same for reads and writes.
- Back-to-back period is `RAM_LAT+2` cycles per transaction.
- Simultaneous IF+MEM at an arbitration point: MEM wins, unless `starve_cnt==STARVE_MAX`, in which case IF wins.
- If `reset`=0 in any state, the in-flight transaction is abandoned. There is no ack and no further `ram_ce`, and all outputs return to their reset values at the next edge.
- `ram_ce` and `ram_we` are never high outside ISSUE. The two acks are never high together.

## Test plan
- **Single IF read.** `RAM_LAT`=1, RAM word at 0x0000_0010 = 0x3C01_1234. Hold `if_req` from c0 → `ram_ce` high in c1 with `ram_addr`=0x10 and `ram_we`=0; `if_ack` high in c3 with `if_rdata`=0x3C01_1234; `busy` high c1–c3.
- **MEM write then read.** Write 0xDEAD_BEEF, sel 4'b1111, to 0x100 → `ram_we`=1 with `ram_ce` in c1; `mem_ack` in c3 with `mem_rdata`=0. A read of 0x100 issued at c3 → `ram_ce` in c4; `mem_ack` in c6 with 0xDEAD_BEEF.
- **Priority/starvation.** `STARVE_MAX`=2, both requests held continuously → grant order is MEM, MEM, IF, MEM, MEM, IF. `starve_cnt` reads 1, 2, 0 across the first three grants.
- **Latency sweep.** Repeat the single read with `RAM_LAT`=3 → `ram_ce` in c1; ack in c5; 4 back-to-back reads complete at c5, c10, c15, c20.
- **Reset mid-transaction.** Drive `reset`=0 in the WAIT cycle of a MEM read → next cycle state is IDLE with all outputs 0; no `mem_ack` ever pulses for that read. After release, a fresh request completes normally.
- **Dropped request.** Deassert `if_req` in c1 → `if_ack` still pulses in c3; `stallreq` equals 0 from c1 if `mem_req`=0.
